gpio_hub: RTL
=============

GPIO_HUB -- requirements
Module: gpio_hub

Interface
REQ-001 Parameter NBTN, default 4: number of push-button channels (1..16).
REQ-002 Parameter SW_W, default 8: slide-switch width, equal to event payload width.
REQ-003 Parameter LED_W, default 8: LED register width.
REQ-004 Parameter DEB_CYC, default 20000: debounce qualification length in clk cycles (>=2).
REQ-005 Parameter LOCK_CYC, default 10000000: post-event lockout length in clk cycles (>=2).
REQ-006 Parameter FIFO_DEPTH, default 4: event queue entries (power of 2, >=2).
REQ-007 clk  in  1  clock; all logic on its rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 btn_in  in  NBTN  raw asynchronous push buttons, active-high.
REQ-010 sw_in  in  SW_W  raw asynchronous slide switches.
REQ-011 led_data  in  LED_W  new LED value.
REQ-012 led_valid  in  1  led_data valid this cycle.
REQ-013 led_ready  out  1  LED port accepts data.
REQ-014 led_out  out  LED_W  registered LED drive.
REQ-015 ev_data  out  SW_W  switch snapshot of head event.
REQ-016 ev_btn  out  clog2(NBTN) (min 1)  button index of head event.
REQ-017 ev_valid  out  1  event queue non-empty.
REQ-018 ev_ready  in  1  consumer accepts head event.
REQ-019 ev_overflow  out  1  sticky: an event was dropped.
REQ-020 ov_clr  in  1  clears ev_overflow.

Function
REQ-021 Each btn_in bit and all of sw_in SHALL pass through a 2-flop synchroniser; only synchronised values are used.
REQ-022 Each button SHALL run an independent FSM with states IDLE, DEBOUNCE, LOCKOUT and its own counter.
REQ-023 IDLE -> DEBOUNCE with counter=1 on synchronised rising edge (current 1, previous 0).
REQ-024 In DEBOUNCE, synchronised low SHALL return to IDLE immediately with counter 0 and no event.
REQ-025 In DEBOUNCE, counter increments each cycle; in the cycle counter==DEB_CYC with input high, set the channel's pend flag and enter LOCKOUT with counter=1.
REQ-026 In LOCKOUT, counter increments to LOCK_CYC, then the FSM enters IDLE; input edges during LOCKOUT SHALL be ignored.
REQ-027 A held button SHALL not retrigger: leaving LOCKOUT still high requires a new rising edge (unless REQ-041).
REQ-028 Arbiter: each cycle, if any pend flag is set, push the lowest-index pending channel and clear its flag; other flags stay set.
REQ-029 Pushed entry = {channel index, synchronised sw_in in the push cycle}.
REQ-030 Latency: with empty queue and no contention, ev_valid SHALL rise 2 cycles after the terminal DEBOUNCE cycle.
REQ-031 ev_valid = queue non-empty; ev_data/ev_btn show the head entry, stable while ev_valid && !ev_ready.
REQ-032 Pop on ev_valid && ev_ready; entries leave in push order.
REQ-033 Push and pop in the same cycle SHALL both take effect, including when full; occupancy unchanged.
REQ-034 Push while full without pop: entry dropped, pend flag cleared, ev_overflow set next cycle.
REQ-035 ov_clr SHALL clear ev_overflow next cycle; a simultaneous drop SHALL win (stays 1).
REQ-036 Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-037 led_ready SHALL be 1 whenever rstn is high; on led_valid, led_out <= led_data next edge; otherwise hold.

Reset
REQ-038 While rstn low at an edge: synchronisers 0, FSMs IDLE, counters 0, pend flags 0, queue empty, ev_valid 0, ev_overflow 0, led_out 0, led_ready 0, ev_data/ev_btn 0.
REQ-039 Reset mid-debounce or mid-lockout SHALL discard channel progress; queued events are lost; no event emitted for an aborted press.

Configuration
REQ-040 Macro GPIO_HUB_AUTOREPEAT_EN selects auto-repeat.
REQ-041 Defined: at LOCKOUT terminal count with input still high, set pend again and restart LOCKOUT (counter=1); repeats continue every LOCK_CYC cycles while held.
REQ-042 Undefined: REQ-027 applies; no repeat logic synthesised.

Verification (NBTN=4, SW_W=8, DEB_CYC=4, LOCK_CYC=16, FIFO_DEPTH=4)
REQ-043 sw_in=0xA5, btn_in[2] high 40 cycles, ev_ready=1 -> one event ev_btn=2 ev_data=0xA5; ev_valid one cycle; no repeat (macro undefined).
REQ-044 btn_in[1] high 2 cycles then low -> no event; FSM back to IDLE.
REQ-045 btn_in[0] and btn_in[3] rise same cycle, ev_ready=0 -> head ev_btn=0, next ev_btn=3, consecutive push cycles.
REQ-046 ev_ready=0, 5 separate qualified presses -> 4 queued, ev_overflow=1; ov_clr pulse -> 0; drain 4 in order.
REQ-047 Macro defined, btn_in[1] held 60 cycles -> events at terminal DEBOUNCE then every 16 cycles while held.
REQ-048 led_valid with led_data=0x3C -> led_out=0x3C next cycle; rstn low mid-lockout -> led_out=0, queue empty, no late event.

Source files
------------

// File: rtl/gpio_hub.sv
// rtl/gpio_hub.sv - debounced push-button event hub with switch snapshot queue and LED register
//
// Optional feature: define GPIO_HUB_AUTOREPEAT_EN to make a held button
// re-emit an event at the end of every lockout period.
//
// Ports:
//   clk, rstn           clock (rising edge), synchronous active-low reset
//   btn_in[NBTN]        raw push buttons, active-high
//   sw_in[SW_W]         raw slide switches, snapshotted into each event
//   led_data/led_valid  LED write; led_ready high whenever out of reset
//   led_out             registered LED drive
//   ev_data/ev_btn      head event: switch snapshot and button index
//   ev_valid/ev_ready   event queue handshake, pop on valid && ready
//   ev_overflow/ov_clr  sticky drop flag and its clear
module gpio_hub #(
    parameter int NBTN       = 4,
    parameter int SW_W       = 8,
    parameter int LED_W      = 8,
    parameter int DEB_CYC    = 20000,
    parameter int LOCK_CYC   = 10000000,
    parameter int FIFO_DEPTH = 4,
    localparam int BTN_W     = (NBTN > 1) ? $clog2(NBTN) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NBTN-1:0]  btn_in,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [LED_W-1:0] led_data,
    input  logic             led_valid,
    output logic             led_ready,
    output logic [LED_W-1:0] led_out,
    output logic [SW_W-1:0]  ev_data,
    output logic [BTN_W-1:0] ev_btn,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_overflow,
    input  logic             ov_clr
);

    localparam int CNT_MAX = (DEB_CYC > LOCK_CYC) ? DEB_CYC : LOCK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENT_W   = BTN_W + SW_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_LOCKOUT
    } state_t;

    // Two-flop synchronisers; btn_prev is one more stage used only for edge detection.
    logic [NBTN-1:0] btn_meta, btn_s, btn_prev;
    logic [SW_W-1:0] sw_meta, sw_s;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            btn_meta <= '0;
            btn_s    <= '0;
            btn_prev <= '0;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
            btn_prev <= btn_s;
            sw_meta  <= sw_in;
            sw_s     <= sw_meta;
        end
    end

    // Per-button debounce / lockout FSMs.
    state_t           state_q [NBTN];
    state_t           state_d [NBTN];
    logic [CNT_W-1:0] cnt_q   [NBTN];
    logic [CNT_W-1:0] cnt_d   [NBTN];
    logic [NBTN-1:0]  qual;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            qual[i]    = 1'b0;
            case (state_q[i])
                S_IDLE: begin
                    if (btn_s[i] && !btn_prev[i]) begin
                        state_d[i] = S_DEBOUNCE;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!btn_s[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(DEB_CYC)) begin
                        qual[i]    = 1'b1;
                        state_d[i] = S_LOCKOUT;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (cnt_q[i] == CNT_W'(LOCK_CYC)) begin
`ifdef GPIO_HUB_AUTOREPEAT_EN
                        if (btn_s[i]) begin
                            qual[i]  = 1'b1;
                            cnt_d[i] = CNT_W'(1);
                        end else begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end
`else
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Pending flags and fixed-priority arbiter: lowest index wins, one push per cycle.
    logic [NBTN-1:0]  pend_q;
    logic [NBTN-1:0]  sel_mask;
    logic [BTN_W-1:0] sel_idx;
    logic             push_req;

    always_comb begin
        sel_idx  = '0;
        push_req = |pend_q;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = BTN_W'(i);
            end
        end
        sel_mask = push_req ? (NBTN'(1) << sel_idx) : '0;
    end

    // A new qualification beats the clear of the same channel's flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~sel_mask) | qual;
        end
    end

    // Event queue. The arbitrated entry is consumed even when dropped.
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] count;
    logic             full, pop, wr_en, drop;

    assign ev_valid = (count != '0);
    assign full     = (count == OCC_W'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign wr_en    = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ev_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {sel_idx, sw_s};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ev_overflow <= 1'b1;
            end else if (ov_clr) begin
                ev_overflow <= 1'b0;
            end
        end
    end

    assign {ev_btn, ev_data} = mem[rd_ptr];

    // LED register: always ready out of reset.
    assign led_ready = rstn;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            led_out <= '0;
        end else if (led_valid) begin
            led_out <= led_data;
        end
    end

endmodule
